// File: rtl/ceyloniac_ram_arbiter_if.sv
// Core/external request-acknowledge bundle for ceyloniac_ram_arbiter.
// Byte-enable lanes exist only when CEYLONIAC_RAM_BYTE_ENABLE_EN is defined.
interface ceyloniac_ram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  ram_external_control_enable;
    logic                  core_req;
    logic                  core_write_enable;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_write_data;
    logic                  core_ack;
    logic                  core_read_valid;
    logic [DATA_WIDTH-1:0] core_read_data;
    logic                  ext_req;
    logic                  ext_write_enable;
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0] ext_write_data;
    logic                  ext_ack;
    logic                  ext_read_valid;
    logic [DATA_WIDTH-1:0] ext_read_data;
    logic                  ram_addr_error;
`ifdef CEYLONIAC_RAM_BYTE_ENABLE_EN
    logic [DATA_WIDTH/8-1:0] core_byte_enable;
    logic [DATA_WIDTH/8-1:0] ext_byte_enable;

    modport master (
        output ram_external_control_enable,
        output core_req, core_write_enable, core_addr, core_write_data, core_byte_enable,
        input  core_ack, core_read_valid, core_read_data,
        output ext_req, ext_write_enable, ext_addr, ext_write_data, ext_byte_enable,
        input  ext_ack, ext_read_valid, ext_read_data,
        input  ram_addr_error
    );

    modport slave (
        input  ram_external_control_enable,
        input  core_req, core_write_enable, core_addr, core_write_data, core_byte_enable,
        output core_ack, core_read_valid, core_read_data,
        input  ext_req, ext_write_enable, ext_addr, ext_write_data, ext_byte_enable,
        output ext_ack, ext_read_valid, ext_read_data,
        output ram_addr_error
    );
`else
    modport master (
        output ram_external_control_enable,
        output core_req, core_write_enable, core_addr, core_write_data,
        input  core_ack, core_read_valid, core_read_data,
        output ext_req, ext_write_enable, ext_addr, ext_write_data,
        input  ext_ack, ext_read_valid, ext_read_data,
        input  ram_addr_error
    );

    modport slave (
        input  ram_external_control_enable,
        input  core_req, core_write_enable, core_addr, core_write_data,
        output core_ack, core_read_valid, core_read_data,
        input  ext_req, ext_write_enable, ext_addr, ext_write_data,
        output ext_ack, ext_read_valid, ext_read_data,
        output ram_addr_error
    );
`endif
endinterface

// File: rtl/ceyloniac_ram_arbiter.sv
// Two-port round-robin RAM controller with a one-cycle drain state on ownership change.
// Optional per-byte write enables: define CEYLONIAC_RAM_BYTE_ENABLE_EN.
module ceyloniac_ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ceyloniac_ram_arbiter_if.slave bus
);
    localparam logic [1:0] ST_NORMAL   = 2'd0;
    localparam logic [1:0] ST_SWITCH   = 2'd1;
    localparam logic [1:0] ST_EXTERNAL = 2'd2;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [1:0]            state_r;
    logic [1:0]            state_next_s;
    logic                  last_ext_r;
    logic                  grant_core_s;
    logic                  grant_ext_s;
    logic                  grant_any_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic                  in_range_s;
    logic [IDX_W-1:0]      idx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  core_rvalid_r;
    logic                  ext_rvalid_r;
    logic [DATA_WIDTH-1:0] core_rdata_r;
    logic [DATA_WIDTH-1:0] ext_rdata_r;
    logic                  addr_err_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
`ifdef CEYLONIAC_RAM_BYTE_ENABLE_EN
    localparam int BE_W = DATA_WIDTH / 8;
    logic [BE_W-1:0]       sel_be_s;
`endif

    // Grant selection; acks are held low while reset is asserted.
    always_comb begin
        grant_core_s = 1'b0;
        grant_ext_s  = 1'b0;
        if (rst_n == 1'b0) begin
            grant_core_s = 1'b0;
            grant_ext_s  = 1'b0;
        end else begin
            case (state_r)
                ST_NORMAL: begin
                    if (bus.core_req && bus.ext_req) begin
                        grant_core_s = last_ext_r;
                        grant_ext_s  = ~last_ext_r;
                    end else begin
                        grant_core_s = bus.core_req;
                        grant_ext_s  = bus.ext_req;
                    end
                end
                ST_EXTERNAL: grant_ext_s = bus.ext_req;
                default: begin
                    grant_core_s = 1'b0;
                    grant_ext_s  = 1'b0;
                end
            endcase
        end
    end

    // Mode FSM: any mismatch between enable and current mode passes through SWITCH.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_NORMAL:   state_next_s = bus.ram_external_control_enable ? ST_SWITCH : ST_NORMAL;
            ST_SWITCH:   state_next_s = bus.ram_external_control_enable ? ST_EXTERNAL : ST_NORMAL;
            ST_EXTERNAL: state_next_s = bus.ram_external_control_enable ? ST_EXTERNAL : ST_SWITCH;
            default:     state_next_s = ST_NORMAL;
        endcase
    end

    // Mux the granted port onto the array access path.
    always_comb begin
        grant_any_s = grant_core_s | grant_ext_s;
        if (grant_core_s) begin
            sel_we_s    = bus.core_write_enable;
            sel_addr_s  = bus.core_addr;
            sel_wdata_s = bus.core_write_data;
        end else begin
            sel_we_s    = bus.ext_write_enable;
            sel_addr_s  = bus.ext_addr;
            sel_wdata_s = bus.ext_write_data;
        end
`ifdef CEYLONIAC_RAM_BYTE_ENABLE_EN
        if (grant_core_s) begin
            sel_be_s = bus.core_byte_enable;
        end else begin
            sel_be_s = bus.ext_byte_enable;
        end
`endif
        in_range_s = ({1'b0, sel_addr_s} < DEPTH_L);
        idx_s      = sel_addr_s[IDX_W-1:0];
        if (in_range_s) begin
            rd_word_s = mem_r[idx_s];
        end else begin
            rd_word_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Array writes; out-of-range writes are dropped and contents are never reset.
    always_ff @(posedge clk) begin
        if (grant_any_s && sel_we_s && in_range_s) begin
`ifdef CEYLONIAC_RAM_BYTE_ENABLE_EN
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= sel_wdata_s[8*b +: 8];
                end
            end
`else
            mem_r[idx_s] <= sel_wdata_s;
`endif
        end
    end

    // FSM state, round-robin pointer, read-return and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_NORMAL;
            last_ext_r    <= 1'b1;
            core_rvalid_r <= 1'b0;
            ext_rvalid_r  <= 1'b0;
            core_rdata_r  <= {DATA_WIDTH{1'b0}};
            ext_rdata_r   <= {DATA_WIDTH{1'b0}};
            addr_err_r    <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            core_rvalid_r <= grant_core_s & ~sel_we_s;
            ext_rvalid_r  <= grant_ext_s & ~sel_we_s;
            addr_err_r    <= grant_any_s & ~in_range_s;
            if (grant_any_s) begin
                last_ext_r <= grant_ext_s;
            end
            if (grant_core_s && !sel_we_s) begin
                core_rdata_r <= rd_word_s;
            end
            if (grant_ext_s && !sel_we_s) begin
                ext_rdata_r <= rd_word_s;
            end
        end
    end

    assign bus.core_ack        = grant_core_s;
    assign bus.ext_ack         = grant_ext_s;
    assign bus.core_read_valid = core_rvalid_r;
    assign bus.ext_read_valid  = ext_rvalid_r;
    assign bus.core_read_data  = core_rdata_r;
    assign bus.ext_read_data   = ext_rdata_r;
    assign bus.ram_addr_error  = addr_err_r;
endmodule

// File: tb/tb_ceyloniac_ram_arbiter.sv
// Directed self-checking bench for ceyloniac_ram_arbiter (DEPTH=1024, 32-bit words).
// Define CEYLONIAC_RAM_BYTE_ENABLE_EN to include the byte-lane write check.
module tb_ceyloniac_ram_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   core_acks;
    int   ext_acks;

    always #5 clk = ~clk;

    ceyloniac_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ceyloniac_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic core_drive(input logic req, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data);
        bus.core_req          = req;
        bus.core_write_enable = we;
        bus.core_addr         = addr;
        bus.core_write_data   = data;
    endtask

    task automatic ext_drive(input logic req, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data);
        bus.ext_req          = req;
        bus.ext_write_enable = we;
        bus.ext_addr         = addr;
        bus.ext_write_data   = data;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_core_ack"}, {31'd0, bus.core_ack}, 32'd0);
        check_eq({tag, "_ext_ack"}, {31'd0, bus.ext_ack}, 32'd0);
        check_eq({tag, "_core_rv"}, {31'd0, bus.core_read_valid}, 32'd0);
        check_eq({tag, "_ext_rv"}, {31'd0, bus.ext_read_valid}, 32'd0);
        check_eq({tag, "_core_rd"}, bus.core_read_data, 32'd0);
        check_eq({tag, "_ext_rd"}, bus.ext_read_data, 32'd0);
        check_eq({tag, "_err"}, {31'd0, bus.ram_addr_error}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ram_external_control_enable = 1'b0;
        core_drive(1'b0, 1'b0, 16'd0, 32'd0);
        ext_drive(1'b0, 1'b0, 16'd0, 32'd0);
`ifdef CEYLONIAC_RAM_BYTE_ENABLE_EN
        bus.core_byte_enable = 4'hF;
        bus.ext_byte_enable  = 4'hF;
`endif
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: reads on both ports every cycle, core wins first tie.
        core_acks = 0;
        ext_acks  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            core_drive(1'b1, 1'b0, 16'd0, 32'd0);
            ext_drive(1'b1, 1'b0, 16'd1, 32'd0);
            #1;
            check_eq("cont_core_ack", {31'd0, bus.core_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("cont_ext_ack", {31'd0, bus.ext_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i > 0) begin
                check_eq("cont_core_rv", {31'd0, bus.core_read_valid}, ((i - 1) % 2 == 0) ? 32'd1 : 32'd0);
                check_eq("cont_ext_rv", {31'd0, bus.ext_read_valid}, ((i - 1) % 2 == 1) ? 32'd1 : 32'd0);
            end
            core_acks += int'(bus.core_ack);
            ext_acks  += int'(bus.ext_ack);
        end
        check_eq("cont_core_count", 32'(core_acks), 32'd3);
        check_eq("cont_ext_count", 32'(ext_acks), 32'd3);
        @(negedge clk);
        core_drive(1'b0, 1'b0, 16'd0, 32'd0);
        ext_drive(1'b0, 1'b0, 16'd0, 32'd0);
        #1;
        check_eq("cont_tail_core_rv", {31'd0, bus.core_read_valid}, 32'd0);
        check_eq("cont_tail_ext_rv", {31'd0, bus.ext_read_valid}, 32'd1);

        // Loader then core: enable high, one dead SWITCH cycle, then ext writes 1..6.
        @(negedge clk);
        bus.ram_external_control_enable = 1'b1;
        @(negedge clk);
        ext_drive(1'b1, 1'b1, 16'd1, 32'd1);
        #1;
        check_eq("load_switch_ack", {31'd0, bus.ext_ack}, 32'd0);
        for (int a = 1; a <= 6; a++) begin
            @(negedge clk);
            ext_drive(1'b1, 1'b1, AW'(a), 32'(a));
            #1;
            check_eq("load_ext_wr_ack", {31'd0, bus.ext_ack}, 32'd1);
        end
        @(negedge clk);
        ext_drive(1'b0, 1'b0, 16'd0, 32'd0);
        bus.ram_external_control_enable = 1'b0;
        core_drive(1'b1, 1'b0, 16'd2, 32'd0);
        #1;
        check_eq("load_ext_mode_core_ack", {31'd0, bus.core_ack}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("load_switch_core_ack", {31'd0, bus.core_ack}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("load_core_ack_a2", {31'd0, bus.core_ack}, 32'd1);
        @(negedge clk);
        core_drive(1'b1, 1'b0, 16'd3, 32'd0);
        #1;
        check_eq("load_core_rv_a2", {31'd0, bus.core_read_valid}, 32'd1);
        check_eq("load_core_rd_a2", bus.core_read_data, 32'd2);
        check_eq("load_core_ack_a3", {31'd0, bus.core_ack}, 32'd1);
        @(negedge clk);
        core_drive(1'b0, 1'b0, 16'd0, 32'd0);
        #1;
        check_eq("load_core_rv_a3", {31'd0, bus.core_read_valid}, 32'd1);
        check_eq("load_core_rd_a3", bus.core_read_data, 32'd3);
        @(negedge clk);
        #1;
        check_eq("load_core_rv_drop", {31'd0, bus.core_read_valid}, 32'd0);
        check_eq("load_core_rd_hold", bus.core_read_data, 32'd3);

        // Exclusive mode: core held off while ext reads run back to back.
        @(negedge clk);
        bus.ram_external_control_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            core_drive(1'b1, 1'b0, 16'd1, 32'd0);
            ext_drive(1'b1, 1'b0, AW'(k + 1), 32'd0);
            #1;
            check_eq("excl_core_ack", {31'd0, bus.core_ack}, 32'd0);
            check_eq("excl_ext_ack", {31'd0, bus.ext_ack}, 32'd1);
            if (k > 0) begin
                check_eq("excl_ext_rv", {31'd0, bus.ext_read_valid}, 32'd1);
                check_eq("excl_ext_rd", bus.ext_read_data, 32'(k));
            end
        end
        @(negedge clk);
        ext_drive(1'b0, 1'b0, 16'd0, 32'd0);
        bus.ram_external_control_enable = 1'b0;
        #1;
        check_eq("excl_ext_rd_last", bus.ext_read_data, 32'd5);
        check_eq("excl_exit_core_ack", {31'd0, bus.core_ack}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("excl_switch_core_ack", {31'd0, bus.core_ack}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("excl_normal_core_ack", {31'd0, bus.core_ack}, 32'd1);
        @(negedge clk);
        core_drive(1'b0, 1'b0, 16'd0, 32'd0);
        #1;
        check_eq("excl_core_rd", bus.core_read_data, 32'd1);

        // Out of range: seed addr 0 and 1023, then hit 1024 (aliases index 0 if unguarded).
        @(negedge clk);
        core_drive(1'b1, 1'b1, 16'd0, 32'h1111_1111);
        @(negedge clk);
        core_drive(1'b1, 1'b1, 16'd1023, 32'hA5A5_A5A5);
        @(negedge clk);
        core_drive(1'b1, 1'b1, 16'd1024, 32'hDEAD_BEEF);
        #1;
        check_eq("oor_wr_err_prev", {31'd0, bus.ram_addr_error}, 32'd0);
        check_eq("oor_wr_ack", {31'd0, bus.core_ack}, 32'd1);
        @(negedge clk);
        core_drive(1'b1, 1'b0, 16'd1024, 32'd0);
        #1;
        check_eq("oor_wr_err", {31'd0, bus.ram_addr_error}, 32'd1);
        check_eq("oor_wr_no_rv", {31'd0, bus.core_read_valid}, 32'd0);
        check_eq("oor_rd_ack", {31'd0, bus.core_ack}, 32'd1);
        @(negedge clk);
        core_drive(1'b1, 1'b0, 16'd0, 32'd0);
        #1;
        check_eq("oor_rd_err", {31'd0, bus.ram_addr_error}, 32'd1);
        check_eq("oor_rd_rv", {31'd0, bus.core_read_valid}, 32'd1);
        check_eq("oor_rd_data", bus.core_read_data, 32'd0);
        @(negedge clk);
        core_drive(1'b1, 1'b0, 16'd1023, 32'd0);
        #1;
        check_eq("oor_err_cleared", {31'd0, bus.ram_addr_error}, 32'd0);
        check_eq("oor_alias_intact", bus.core_read_data, 32'h1111_1111);
        @(negedge clk);
        core_drive(1'b0, 1'b0, 16'd0, 32'd0);
        #1;
        check_eq("last_word_rd", bus.core_read_data, 32'hA5A5_A5A5);
        check_eq("last_word_err", {31'd0, bus.ram_addr_error}, 32'd0);

        // Reset mid-read: the pending read_valid must never appear.
        @(negedge clk);
        core_drive(1'b1, 1'b0, 16'd5, 32'd0);
        #1;
        check_eq("rst_rd_ack", {31'd0, bus.core_ack}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        check_eq("rst_mid_rv_after_edge", {31'd0, bus.core_read_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rst_first_ack", {31'd0, bus.core_ack}, 32'd1);
        @(negedge clk);
        core_drive(1'b0, 1'b0, 16'd0, 32'd0);
        #1;
        check_eq("rst_first_rv", {31'd0, bus.core_read_valid}, 32'd1);
        check_eq("rst_first_rd", bus.core_read_data, 32'd5);

`ifdef CEYLONIAC_RAM_BYTE_ENABLE_EN
        // Byte lanes 0 and 2 only on the second write.
        @(negedge clk);
        core_drive(1'b1, 1'b1, 16'd8, 32'hFFFF_FFFF);
        bus.core_byte_enable = 4'hF;
        @(negedge clk);
        core_drive(1'b1, 1'b1, 16'd8, 32'h1234_5678);
        bus.core_byte_enable = 4'b0101;
        @(negedge clk);
        core_drive(1'b1, 1'b0, 16'd8, 32'd0);
        bus.core_byte_enable = 4'b0000;
        @(negedge clk);
        core_drive(1'b0, 1'b0, 16'd0, 32'd0);
        bus.core_byte_enable = 4'hF;
        #1;
        check_eq("be_rd", bus.core_read_data, 32'hFF34_FF78);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
